// File: rtl/swm_tx_packer.sv
// Avalon-ST to SerialLite III TX adapter: packs K sink words per beat, splits bursts, buffers beats in a FIFO.
// States: IDLE = waiting for SOP word | IN_PKT = packet open, accumulating words.
module swm_tx_packer #(
    parameter int          SINK_W          = 32,
    parameter int          LANES           = 4,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_BURST_BEATS = 16,
    parameter logic [7:0]  FILL_BYTE       = 8'hBC,
    localparam int         TX_W            = 64 * LANES
) (
    input  logic              clk_in_clk,
    input  logic              reset_in_rst_n,
    input  logic [SINK_W-1:0] avalonst_sink_data,
    input  logic              avalonst_sink_valid,
    input  logic              avalonst_sink_startofpacket,
    input  logic              avalonst_sink_endofpacket,
    output logic              avalonst_sink_ready,
    output logic [TX_W-1:0]   data_tx,
    output logic              valid_tx,
    output logic              start_of_burst_tx,
    output logic              end_of_burst_tx,
    input  logic [3:0]        error_tx,
    output logic [7:0]        sync_tx,
    input  logic              ready_tx,
    output logic [3:0]        status_err_tx,
    output logic [1:0]        status_err_proto,
    input  logic              status_clear,
    output logic [31:0]       beats_sent
);

    localparam int K     = TX_W / SINK_W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(MAX_BURST_BEATS + 1);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_IN_PKT   = 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(K - 1);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST_BEATS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [TX_W-1:0]  FILL_VEC   = {(TX_W / 8){FILL_BYTE}};

    typedef struct packed {
        logic            sob;
        logic            eob;
        logic [TX_W-1:0] data;
    } beat_t;

    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic [TX_W-1:0]  hold;
    logic [BC_W-1:0]  burst_cnt;
    beat_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic       accept;
    logic       take;
    logic       push;
    logic       pop;
    logic [1:0] proto_set;
    beat_t      beat;

    assign accept = avalonst_sink_valid && avalonst_sink_ready;
    assign pop    = valid_tx && ready_tx;

    always_comb begin
        take      = 1'b0;
        proto_set = 2'b00;
        if (accept) begin
            if (state == S_IDLE) begin
                take         = avalonst_sink_startofpacket;
                proto_set[1] = !avalonst_sink_startofpacket;
            end else begin
                take         = 1'b1;
                proto_set[0] = avalonst_sink_startofpacket;
            end
        end
        push = take && (avalonst_sink_endofpacket || (idx == IDX_LAST));
    end

    // Held words below idx, incoming word at idx, pad bytes above.
    always_comb begin
        beat.data = FILL_VEC;
        for (int j = 0; j < K; j++) begin
            if (j < int'(idx))
                beat.data[j*SINK_W +: SINK_W] = hold[j*SINK_W +: SINK_W];
            else if (j == int'(idx))
                beat.data[j*SINK_W +: SINK_W] = avalonst_sink_data;
        end
        beat.sob = (burst_cnt == '0);
        beat.eob = avalonst_sink_endofpacket || (burst_cnt == BURST_LAST);
    end

    always_comb begin
        count_next = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            hold      <= '0;
            burst_cnt <= '0;
        end else if (take) begin
            state <= avalonst_sink_endofpacket ? S_IDLE : S_IN_PKT;
            hold[idx*SINK_W +: SINK_W] <= avalonst_sink_data;
            if (push) begin
                idx       <= '0;
                burst_cnt <= beat.eob ? '0 : burst_cnt + BC_W'(1);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            avalonst_sink_ready <= 1'b0;
            beats_sent          <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= beat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                beats_sent <= beats_sent + 32'd1;
            end
            count               <= count_next;
            avalonst_sink_ready <= (count_next < DEPTH_C);
        end
    end

    always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
        if (!reset_in_rst_n) begin
            status_err_tx    <= '0;
            status_err_proto <= '0;
        end else begin
            status_err_tx    <= (status_clear ? 4'b0 : status_err_tx) | error_tx;
            status_err_proto <= (status_clear ? 2'b0 : status_err_proto) | proto_set;
        end
    end

    assign valid_tx          = (count != '0);
    assign data_tx           = mem[rd_ptr].data;
    assign start_of_burst_tx = mem[rd_ptr].sob;
    assign end_of_burst_tx   = mem[rd_ptr].eob;
    assign sync_tx           = 8'(LANES);

endmodule

// File: tb/tb_swm_tx_packer.sv
// Randomized bench for swm_tx_packer; a packet-level model turns whole packets into expected beats.
module tb_swm_tx_packer;

    localparam int SINK_W = 32;
    localparam int TX_W   = 256;
    localparam int K      = 8;
    localparam int MAXB   = 16;
    localparam logic [7:0] FILL = 8'hBC;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [SINK_W-1:0] sink_data = '0;
    logic              sink_valid = 1'b0;
    logic              sink_sop = 1'b0;
    logic              sink_eop = 1'b0;
    logic              sink_ready;
    logic [TX_W-1:0]   data_tx;
    logic              valid_tx;
    logic              sob_tx;
    logic              eob_tx;
    logic [3:0]        error_tx = '0;
    logic [7:0]        sync_tx;
    logic              ready_tx = 1'b0;
    logic [3:0]        status_err_tx;
    logic [1:0]        status_err_proto;
    logic              status_clear = 1'b0;
    logic [31:0]       beats_sent;

    always #5 clk = ~clk;

    swm_tx_packer dut (
        .clk_in_clk                  (clk),
        .reset_in_rst_n              (rst_n),
        .avalonst_sink_data          (sink_data),
        .avalonst_sink_valid         (sink_valid),
        .avalonst_sink_startofpacket (sink_sop),
        .avalonst_sink_endofpacket   (sink_eop),
        .avalonst_sink_ready         (sink_ready),
        .data_tx                     (data_tx),
        .valid_tx                    (valid_tx),
        .start_of_burst_tx           (sob_tx),
        .end_of_burst_tx             (eob_tx),
        .error_tx                    (error_tx),
        .sync_tx                     (sync_tx),
        .ready_tx                    (ready_tx),
        .status_err_tx               (status_err_tx),
        .status_err_proto            (status_err_proto),
        .status_clear                (status_clear),
        .beats_sent                  (beats_sent)
    );

    typedef struct {
        logic [TX_W-1:0] data;
        logic            sob;
        logic            eob;
    } beat_t;

    int checks = 0;
    int failures = 0;

    beat_t             exp_q[$];
    beat_t             obs_q[$];
    logic [SINK_W-1:0] pkt_words[$];
    bit                m_in_pkt = 0;
    logic [1:0]        m_proto = '0;
    int                exp_sent = 0;
    int                rdy_mode = 0;
    bit                drv_done = 0;
    logic [TX_W-1:0]   first_data;

    task automatic chk(input string tag, input logic [TX_W-1:0] got, input logic [TX_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TX_W-1:0] fill_vec();
        logic [TX_W-1:0] v;
        for (int b = 0; b < TX_W / 8; b++) v[b*8 +: 8] = FILL;
        return v;
    endfunction

    // Whole packet -> beats of K words, padded; bursts are runs of MAXB beats.
    function automatic void model_pkt();
        int n  = pkt_words.size();
        int nb = (n + K - 1) / K;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.data = fill_vec();
            for (int w = 0; w < K; w++)
                if (b * K + w < n) e.data[w*SINK_W +: SINK_W] = pkt_words[b*K + w];
            e.sob = (b % MAXB == 0);
            e.eob = (b % MAXB == MAXB - 1) || (b == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void model_word(input logic [SINK_W-1:0] w, input bit sop, input bit eop);
        if (!m_in_pkt) begin
            if (!sop) begin
                m_proto[1] = 1'b1;
                return;
            end
            pkt_words.delete();
            m_in_pkt = 1;
        end else if (sop) begin
            m_proto[0] = 1'b1;
        end
        pkt_words.push_back(w);
        if (eop) begin
            model_pkt();
            m_in_pkt = 0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [SINK_W-1:0] w, input bit sop, input bit eop);
        bit acc = 0;
        int t = 0;
        sink_data  = w;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_valid = 1'b1;
        while (!acc && t < 2000) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            #1;
            t++;
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        if (!acc) chk("send_timeout", acc, 1);
        else model_word(w, sop, eop);
    endtask

    task automatic send_pkt(input int n, input bit rnd, input logic [SINK_W-1:0] base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send(rnd ? $urandom : base + i, i == 0, i == n - 1);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 3000) begin
            idle(1);
            t++;
        end
        idle(3);
        chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
            chk({tag, "_sob"}, obs_q[i].sob, exp_q[i].sob);
            chk({tag, "_eob"}, obs_q[i].eob, exp_q[i].eob);
        end
        first_data = (obs_q.size() > 0) ? obs_q[0].data : '0;
        exp_sent += exp_q.size();
        chk({tag, "_beats_sent"}, beats_sent, exp_sent);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sink_ready"}, sink_ready, 0);
        chk({tag, "_valid"}, valid_tx, 0);
        chk({tag, "_data"}, data_tx, 0);
        chk({tag, "_sob"}, sob_tx, 0);
        chk({tag, "_eob"}, eob_tx, 0);
        chk({tag, "_sync"}, sync_tx, 8'd4);
        chk({tag, "_beats"}, beats_sent, 0);
        chk({tag, "_err_tx"}, status_err_tx, 0);
        chk({tag, "_err_proto"}, status_err_proto, 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready_tx = 1'b1;
            1:       ready_tx = 1'($urandom_range(0, 1));
            default: ready_tx = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && valid_tx && ready_tx) obs_q.push_back('{data_tx, sob_tx, eob_tx});
    end

    initial begin
        logic [TX_W-1:0] head;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(2);

        rdy_mode = 0;
        send_pkt(8, 0, 32'h0, 0);
        drain("pkt8");
        chk("pkt8_literal", first_data,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);

        send(32'hAAAA0001, 1, 0);
        send(32'hBBBB0002, 0, 0);
        send(32'hCCCC0003, 0, 1);
        drain("pkt3");
        chk("pkt3_literal", first_data, {{20{8'hBC}}, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});

        rdy_mode = 1;
        send_pkt(200, 1, 0, 0);
        drain("pkt200");

        rdy_mode = 2;
        idle(1);
        drv_done = 0;
        fork
            begin
                send_pkt(48, 0, 32'h1000, 0);
                drv_done = 1;
            end
        join_none
        idle(40);
        for (int w = 0; w < K; w++) head[w*SINK_W +: SINK_W] = 32'h1000 + w;
        chk("bp_sink_ready", sink_ready, 0);
        chk("bp_valid", valid_tx, 1);
        chk("bp_head", data_tx, head);
        idle(5);
        chk("bp_head_stable", data_tx, head);
        chk("bp_no_pops", obs_q.size(), 0);
        rdy_mode = 0;
        begin
            int t = 0;
            while (!drv_done && t < 3000) begin
                idle(1);
                t++;
            end
        end
        chk("bp_drv_done", drv_done, 1);
        drain("bp");

        send(32'hDEAD0000, 0, 0);
        idle(2);
        chk("proto_idle", status_err_proto, m_proto);
        chk("proto_idle_lit", status_err_proto, 2'b10);
        for (int i = 0; i < 10; i++) send(32'h2000 + i, i == 0 || i == 4, i == 9);
        drain("proto_pkt");
        chk("proto_mid", status_err_proto, 2'b11);
        status_clear = 1'b1;
        idle(1);
        status_clear = 1'b0;
        m_proto = '0;
        chk("proto_clear", status_err_proto, m_proto);

        error_tx = 4'b0100;
        idle(1);
        error_tx = 4'b0000;
        idle(3);
        chk("err_tx_held", status_err_tx, 4'b0100);
        status_clear = 1'b1;
        error_tx = 4'b0001;
        idle(1);
        status_clear = 1'b0;
        error_tx = 4'b0000;
        idle(1);
        chk("err_tx_set_wins", status_err_tx, 4'b0001);

        rdy_mode = 1;
        for (int p = 0; p < 12; p++) send_pkt($urandom_range(1, 40), 1, 0, 1);
        drain("rand");

        rdy_mode = 0;
        send(32'h3000, 1, 0);
        send(32'h3001, 0, 0);
        send(32'h3002, 0, 0);
        rst_n = 1'b0;
        m_in_pkt = 0;
        pkt_words.delete();
        exp_q.delete();
        obs_q.delete();
        exp_sent = 0;
        m_proto = '0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        idle(2);
        send_pkt(8, 0, 32'h4000, 0);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swm_tx_packer.md
Name: swm_tx_packer

Overview:
- Parametrised Avalon-ST to SerialLite III TX adapter.
- Accepts narrow Avalon-ST words and packs K = TX_W/SINK_W words per SerialLite III beat, lowest word in lowest bits.
- Splits long packets into bursts of bounded length and buffers beats in a small FIFO so back-pressure from `ready_tx` does not stall the sink combinationally.
- Sits between the message source and the SerialLite III IP TX user interface; pads partial beats with the 0xBC word-alignment byte.

Parameters:
- SINK_W, 32: Avalon-ST sink data width in bits; TX_W must be an integer multiple of it.
- LANES, 4: number of 64-bit words per TX cycle; TX_W = 64*LANES; driven on `sync_tx`.
- FIFO_DEPTH, 4: beat FIFO entries; power of two, ≥2.
- MAX_BURST_BEATS, 16: maximum beats per SerialLite burst, ≥1.
- FILL_BYTE, 8'hBC: pad byte for unused data bits.

Ports:
- `clk_in_clk` in 1: single clock.
- `reset_in_rst_n` in 1: asynchronous, active-low reset.
- `avalonst_sink_data` in SINK_W: sink word.
- `avalonst_sink_valid` in 1: sink word valid.
- `avalonst_sink_startofpacket` in 1: first word of packet.
- `avalonst_sink_endofpacket` in 1: last word of packet.
- `avalonst_sink_ready` out 1: sink may transfer this cycle.
- `data_tx` out TX_W: TX beat data.
- `valid_tx` out 1: beat valid.
- `start_of_burst_tx` out 1: first beat of burst.
- `end_of_burst_tx` out 1: last beat of burst.
- `error_tx` in 4: IP error flags.
- `sync_tx` out 8: constant LANES.
- `ready_tx` in 1: IP accepts beat.
- `status_err_tx` out 4: sticky OR of `error_tx`.
- `status_err_proto` out 2: sticky; bit0 = SOP while in packet, bit1 = word without SOP while idle.
- `status_clear` in 1: synchronous clear of both status fields.
- `beats_sent` out 32: count of beats handed to the IP; wraps.

Behaviour:
- **Reset values:** `avalonst_sink_ready`=0 while reset is asserted; all other outputs 0 except `sync_tx`=LANES; `data_tx`=0. FIFO empty, state IDLE, pack index 0.
- **Sink handshake:** transfer when valid && ready. `avalonst_sink_ready` = (FIFO count < FIFO_DEPTH), registered, so a push into a full FIFO is impossible.
- **State machine IDLE:**
  - A transfer with SOP goes to IN_PKT, starting a packet and a new burst.
  - A transfer without SOP is dropped and sets `status_err_proto[1]`.
  - SOP and EOP on the same word: a single-word packet; the beat is pushed and the state stays IDLE.
- **State machine IN_PKT:**
  - Words are packed at index i into bits [SINK_W*i +: SINK_W].
  - SOP on a word here sets `status_err_proto[0]`; the word is treated as a continuation.
  - The EOP word returns the state to IDLE.
- **Beat push:** pushed in the same cycle as the accepted word that fills index K-1 or carries EOP. The push combines the held words with the incoming word; unused bits are filled with FILL_BYTE. Pack index then returns to 0.
- **Burst flags:**
  - `start_of_burst_tx`=1 on the first beat of a packet and on the first beat after a forced split.
  - `end_of_burst_tx`=1 on the EOP beat, or on the beat that makes the burst beat count equal MAX_BURST_BEATS; that beat is a forced split.
  - A beat may carry both flags.
  - The burst counter resets on each push with `end_of_burst_tx`.
- **Output and latency:**
  - `valid_tx` = FIFO not empty; `data_tx` and the flags come from the FIFO head.
  - Pop when `valid_tx` && `ready_tx`; `beats_sent` increments on each pop.
  - A pushed beat appears on `valid_tx` the cycle after push when the FIFO was empty.
- **Simultaneous push/pop:** allowed at any count < FIFO_DEPTH; count unchanged. The head is held stable while `ready_tx`=0.
- **Status:**
  - Status bits set on any cycle their condition holds.
  - `status_clear` clears them; a set condition in the same cycle as `status_clear` wins.
- **Reset mid-operation:** a partial beat and FIFO contents are discarded; there is no flush.

Test Plan (defaults, K=8):
- Reset, then an 8-word packet 0x0..0x7 with `ready_tx`=1 → one beat, `data_tx[255:0]`=0x00000007_..._00000000, SOB=EOB=1; `beats_sent`=1.
- 3-word packet A,B,C → beat with words A,B,C in bits [95:0]; bits [255:96] all 0xBC; SOB=EOB=1.
- 200-word packet (25 beats), MAX_BURST_BEATS=16 → burst 1 spans beats 1–16 (SOB on beat 1, EOB on beat 16); burst 2 spans beats 17–25 (SOB on 17, EOB on 25).
- Hold `ready_tx`=0 while streaming → after 4 beats `avalonst_sink_ready`=0; head data stable. Release `ready_tx` → beats emerge in order, none lost or duplicated.
- Word without SOP while idle → dropped, `status_err_proto`=2'b10. SOP mid-packet → 2'b11, packet completes normally. `status_clear` → 0.
- `error_tx`=4'b0100 for 1 cycle → `status_err_tx`=4'b0100 held. Assert reset mid-packet → all outputs at reset values; next packet is packed from index 0.
